uart_rx_ctrl: RTL and testbench

//  Drains frames from a uart_rx receiver into a small FIFO for game/control logic.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_fifo.sv | 66 ++++++
 rtl/uart_rx_ctrl.sv | 129 ++++++++++++
 tb/tb_uart_rx_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type and constants for the uart_rx drain controller
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    FLUSH,
    WAIT_CLR
  } rx_ctrl_state_t;

  localparam int UART_ERRCNT_W = 8;

  function automatic logic [UART_ERRCNT_W-1:0] sat_inc(input logic [UART_ERRCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronous first-word fall-through byte FIFO
// dout_o reads zero while empty so the head output is defined after reset.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == FULL_LVL);
  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    level_d = level_q;
    if (do_pop) rd_d = rd_q + 1'b1;
    if (do_push) wr_d = wr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_q    <= '0;
      wr_q    <= '0;
      level_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && do_push) mem_q[wr_q] <= din_i;
  end

  assign dout_o  = empty_o ? '0 : mem_q[rd_q];
  assign level_o = level_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - drains uart_rx frames into a FIFO with parity filtering and error flags
// Optional busy-stuck timeout enabled by defining UART_RX_CTRL_TIMEOUT_EN.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int FRAME_BITS     = 8,
  parameter int DEPTH          = 8,
  parameter int DROP_BAD       = 1,
  parameter int TIMEOUT_CYCLES = 2047
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_converted,
  input  logic                     i_data_valid,
  input  logic                     i_busy,
  input  logic [FRAME_BITS-1:0]    i_data,
  output logic                     o_rx_flush,
  output logic [FRAME_BITS-1:0]    o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overflow,
  output logic [7:0]               o_par_errs,
  output logic                     o_timeout,
  input  logic                     i_clr
);

  rx_ctrl_state_t           state_q, state_d;
  logic                     push_req, par_ev, ovf_ev;
  logic                     fifo_full, fifo_empty;
  logic                     ovf_q, ovf_d;
  logic [UART_ERRCNT_W-1:0] par_q, par_d;

  always_comb begin
    state_d  = state_q;
    push_req = 1'b0;
    par_ev   = 1'b0;
    case (state_q)
      IDLE:     if (i_converted) state_d = CAPTURE;
      CAPTURE: begin
        state_d  = FLUSH;
        push_req = i_data_valid | (DROP_BAD == 0);
        par_ev   = ~i_data_valid;
      end
      FLUSH:    state_d = WAIT_CLR;
      // Holding here until converted drops keeps one frame from being taken twice.
      WAIT_CLR: if (!i_converted) state_d = IDLE;
      default:  state_d = FLUSH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= FLUSH;
    else          state_q <= state_d;
  end

  assign o_rx_flush = (state_q == FLUSH);

  uart_rx_fifo #(
    .WIDTH (FRAME_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .push_i  (push_req),
    .pop_i   (i_ready),
    .din_i   (i_data),
    .dout_o  (o_data),
    .level_o (o_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign o_valid = ~fifo_empty;
  assign ovf_ev  = push_req & fifo_full & ~i_ready;

  // A fresh event outranks a simultaneous clear.
  always_comb begin
    ovf_d = i_clr ? 1'b0 : ovf_q;
    if (ovf_ev) ovf_d = 1'b1;
    par_d = i_clr ? '0 : par_q;
    if (par_ev) par_d = i_clr ? UART_ERRCNT_W'(1) : sat_inc(par_q);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ovf_q <= 1'b0;
      par_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      par_q <= par_d;
    end
  end

  assign o_overflow = ovf_q;
  assign o_par_errs = par_q;

`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          to_q, to_d;

  always_comb begin
    to_cnt_d = '0;
    if (i_busy) to_cnt_d = (to_cnt_q == TO_LIM) ? to_cnt_q : to_cnt_q + 1'b1;
    to_d = i_clr ? 1'b0 : to_q;
    if (i_busy && (to_cnt_d == TO_LIM)) to_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      to_cnt_q <= '0;
      to_q     <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_q     <= to_d;
    end
  end

  assign o_timeout = to_q;
`else
  logic unused_busy;
  assign unused_busy = i_busy ^ (TIMEOUT_CYCLES == 0);
  assign o_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - randomized self-checking bench for uart_rx_ctrl against a queue model
module tb_uart_rx_ctrl;

  localparam int FB    = 8;
  localparam int DEPTH = 8;
  localparam int TO    = 100;
`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          i_rst_n, i_converted, i_data_valid, i_busy, i_ready, i_clr;
  logic [FB-1:0] i_data;
  logic          o_rx_flush, o_valid, o_overflow, o_timeout;
  logic [FB-1:0] o_data;
  logic [3:0]    o_level;
  logic [7:0]    o_par_errs;

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .FRAME_BITS     (FB),
    .DEPTH          (DEPTH),
    .DROP_BAD       (1),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (i_rst_n),
    .i_converted  (i_converted),
    .i_data_valid (i_data_valid),
    .i_busy       (i_busy),
    .i_data       (i_data),
    .o_rx_flush   (o_rx_flush),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_level      (o_level),
    .o_overflow   (o_overflow),
    .o_par_errs   (o_par_errs),
    .o_timeout    (o_timeout),
    .i_clr        (i_clr)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle", nm, act, exp);
    end
  endtask

  // Reference model: a byte queue plus flag/counter values, advanced once per clock edge.
  logic [FB-1:0] q[$];
  int            cyc      = 0;
  int            cap_edge = -1;
  logic [FB-1:0] cap_data = '0;
  bit            cap_dv   = 1'b0;
  bit            m_flush, m_ovf, m_to;
  int            m_par, run;

  always @(posedge clk) begin
    bit pop_ok, at_cap, push_req, new_ovf;
    cyc++;
    if (!i_rst_n) begin
      q.delete();
      m_flush = 1'b1;
      m_ovf   = 1'b0;
      m_par   = 0;
      m_to    = 1'b0;
      run     = 0;
    end else begin
      at_cap   = (cyc == cap_edge);
      m_flush  = at_cap;
      pop_ok   = i_ready && (q.size() > 0);
      push_req = at_cap && cap_dv;
      new_ovf  = push_req && (q.size() == DEPTH) && !pop_ok;
      if (pop_ok) void'(q.pop_front());
      if (push_req && !new_ovf) q.push_back(cap_data);
      if (new_ovf) m_ovf = 1'b1;
      else if (i_clr) m_ovf = 1'b0;
      if (at_cap && !cap_dv) m_par = i_clr ? 1 : ((m_par < 255) ? m_par + 1 : 255);
      else if (i_clr) m_par = 0;
      run = i_busy ? ((run < TO) ? run + 1 : TO) : 0;
      if (TO_EN && i_busy && run == TO) m_to = 1'b1;
      else if (i_clr) m_to = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      check("valid", 32'(o_valid), 32'(q.size() != 0));
      check("level", 32'(o_level), 32'(q.size()));
      if (q.size() != 0) check("data", 32'(o_data), 32'(q[0]));
      check("flush", 32'(o_rx_flush), 32'(m_flush));
      check("overflow", 32'(o_overflow), 32'(m_ovf));
      check("par_errs", 32'(o_par_errs), 32'(m_par));
      check("timeout", 32'(o_timeout), 32'(m_to));
    end
  end

  int rdy_mode  = 0;
  int busy_mode = 0;
  bit clr_rand  = 1'b0;

  task automatic tick();
    @(negedge clk);
    case (rdy_mode)
      0:       i_ready = 1'b0;
      1:       i_ready = 1'b1;
      default: i_ready = 1'($urandom_range(0, 1));
    endcase
    case (busy_mode)
      0:       i_busy = 1'b0;
      1:       i_busy = 1'b1;
      default: i_busy = 1'($urandom_range(0, 1));
    endcase
    i_clr = clr_rand ? ($urandom_range(0, 15) == 0) : 1'b0;
  endtask

  task automatic pulse_clr();
    tick();
    i_clr = 1'b1;
    tick();
  endtask

  // Acts as the receiver: presents a frame, waits for flush, holds converted a while, drops it.
  task automatic send_frame(input logic [FB-1:0] d, input bit dv, input int hold,
                            input bit pop_at_cap, input bit chk_head);
    int n;
    tick();
    i_converted  = 1'b1;
    i_data       = d;
    i_data_valid = dv;
    cap_edge     = cyc + 2;
    cap_data     = d;
    cap_dv       = dv;
    tick();
    n = 1;
    if (pop_at_cap) i_ready = 1'b1;
    while (!o_rx_flush && n < 8) begin
      tick();
      n++;
    end
    check("flush_latency", 32'(n), 32'd2);
    if (chk_head) begin
      check("head_valid", 32'(o_valid), 32'd1);
      check("head_data", 32'(o_data), 32'(d));
    end
    repeat (hold) tick();
    i_converted  = 1'b0;
    i_data       = 8'($urandom);
    i_data_valid = 1'($urandom_range(0, 1));
    repeat ($urandom_range(1, 3)) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    i_rst_n = 1'b0; i_converted = 1'b1; i_data_valid = 1'b1; i_busy = 1'b0;
    i_ready = 1'b0; i_clr = 1'b0; i_data = 8'h77;

    // Reset with converted held high: receiver is flushed, nothing captured.
    repeat (3) tick();
    check("rst_flush", 32'(o_rx_flush), 32'd1);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_level", 32'(o_level), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    i_rst_n = 1'b1;
    repeat (3) tick();
    check("held_no_capture", 32'(o_level), 32'd0);
    i_converted = 1'b0;
    repeat (2) tick();

    // Single good frame, converted held after flush.
    send_frame(8'hA5, 1'b1, 4, 1'b0, 1'b1);
    check("a5_level", 32'(o_level), 32'd1);
    rdy_mode = 1; repeat (2) tick(); rdy_mode = 0;

    // Parity-bad frames are counted and dropped; count saturates.
    send_frame(8'h3C, 1'b0, 0, 1'b0, 1'b0);
    check("par_one", 32'(o_par_errs), 32'd1);
    check("par_no_push", 32'(o_level), 32'd0);
    repeat (255) send_frame(8'h3C, 1'b0, 0, 1'b0, 1'b0);
    check("par_sat", 32'(o_par_errs), 32'd255);
    pulse_clr();
    check("par_clr", 32'(o_par_errs), 32'd0);

    // Nine frames into an eight-deep FIFO with no consumer.
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, $urandom_range(0, 2), 1'b0, 1'b0);
    check("ovf_level", 32'(o_level), 32'd8);
    check("ovf_flag", 32'(o_overflow), 32'd1);
    rdy_mode = 1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("drain_order", 32'(o_data), 32'(i));
    end
    tick();
    check("drain_empty", 32'(o_valid), 32'd0);
    rdy_mode = 0;
    pulse_clr();
    check("ovf_clr", 32'(o_overflow), 32'd0);

    // Full FIFO with a pop on the capture edge: push and pop both happen.
    for (int i = 0; i < 8; i++) send_frame(8'(8'h10 + i), 1'b1, 0, 1'b0, 1'b0);
    send_frame(8'h18, 1'b1, 0, 1'b1, 1'b0);
    check("full_pp_level", 32'(o_level), 32'd8);
    check("full_pp_ovf", 32'(o_overflow), 32'd0);
    check("full_pp_head", 32'(o_data), 32'h11);
    rdy_mode = 1; repeat (10) tick(); rdy_mode = 0;

    // Reset while a frame is pending and the FIFO holds data.
    for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b1, 0, 1'b0, 1'b0);
    i_converted = 1'b1; i_data_valid = 1'b1; i_rst_n = 1'b0;
    repeat (2) tick();
    check("midrst_flush", 32'(o_rx_flush), 32'd1);
    check("midrst_level", 32'(o_level), 32'd0);
    i_rst_n = 1'b1;
    repeat (2) tick();
    i_converted = 1'b0;
    repeat (2) tick();

    // Busy-stuck timeout boundary.
    pulse_clr();
    busy_mode = 1;
    repeat (100) tick();
    check("to_99", 32'(o_timeout), 32'd0);
    tick();
    check("to_100", 32'(o_timeout), 32'(TO_EN));
    busy_mode = 0;
    tick();
    i_clr = 1'b1;
    repeat (2) tick();
    check("to_clr", 32'(o_timeout), 32'd0);

    // Randomized traffic with alternating consumer behaviour and random clears.
    busy_mode = 2;
    clr_rand  = 1'b1;
    for (int i = 0; i < 150; i++) begin
      rdy_mode = ((i / 20) % 2 == 1) ? 2 : 0;
      send_frame(8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 4),
                 $urandom_range(0, 7) == 0, 1'b0);
    end
    rdy_mode = 1; busy_mode = 0; clr_rand = 1'b0;
    repeat (12) tick();
    check("final_empty", 32'(o_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
